ime_joint_streamer: RTL and testbench



---
 rtl/ime_pkg.sv | 42 ++++
 rtl/ime_stream_fifo2.sv | 68 ++++++
 rtl/ime_joint_streamer.sv | 179 +++++++++++++++++
 tb/tb_ime_joint_streamer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ime_pkg.sv
// Shared types and constants for the mutual-information joint stream source.
package ime_pkg;

  localparam int unsigned W_P     = 16;
  localparam int unsigned W_N     = 16;
  localparam int unsigned W_MODE  = 5;
  localparam int unsigned N_X_MAX = 64;
  localparam int unsigned N_Y_MAX = 64;
  localparam int unsigned AW_X    = $clog2(N_X_MAX);
  localparam int unsigned AW_Y    = $clog2(N_Y_MAX);
  localparam int unsigned AW_J    = AW_X + AW_Y;

  localparam int unsigned MODE_ENT_BIT = 0;
  localparam int unsigned MODE_MI_BIT  = 1;
  localparam int unsigned MODE_CMI_BIT = 2;
  localparam int unsigned MODE_KL_BIT  = 3;
  localparam int unsigned MODE_JS_BIT  = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } ime_stream_state_e;

  typedef struct packed {
    logic [W_P-1:0] p_joint;
    logic [W_P-1:0] p_marg_x;
    logic [W_P-1:0] p_marg_y;
    logic           last;
    logic           poison;
  } ime_beat_t;

  localparam int unsigned BEAT_W = $bits(ime_beat_t);

  // True when exactly one mode bit is set and it is the selected one.
  function automatic logic mode_exact1(input logic [W_MODE-1:0] mode,
                                       input int unsigned sel);
    return mode == (W_MODE'(1) << sel);
  endfunction

endpackage

// File: rtl/ime_stream_fifo2.sv
// Two-entry registered FIFO; head entry drives dout directly, push and pop may coincide.
module ime_stream_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] head;
  logic [W-1:0] tail;
  logic [1:0]   cnt;
  logic [1:0]   cnt_next;
  logic         valid_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);

  always_comb begin
    cnt_next = cnt;
    if (do_push && !do_pop) begin
      cnt_next = cnt + 2'd1;
    end else if (!do_push && do_pop) begin
      cnt_next = cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      valid_q <= (cnt_next != 2'd0);
      if (do_pop) begin
        // Popping shifts the tail forward; a simultaneous push refills behind it.
        if (cnt == 2'd2) begin
          head <= tail;
        end else if (do_push) begin
          head <= din;
        end
        if (do_push && (cnt == 2'd2)) begin
          tail <= din;
        end
      end else if (do_push) begin
        if (cnt == 2'd0) begin
          head <= din;
        end else begin
          tail <= din;
        end
      end
    end
  end

  assign dout  = head;
  assign valid = valid_q;
  assign count = cnt;

endmodule

// File: rtl/ime_joint_streamer.sv
// Walks the p(x,y) table row-major with its marginals and streams one beat per cell.
module ime_joint_streamer
  import ime_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [W_N-1:0]    n_x,
  input  logic [W_N-1:0]    n_y,
  input  logic [W_MODE-1:0] mode_onehot,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              joint_rd_en,
  output logic [AW_J-1:0]   joint_rd_addr,
  input  logic [W_P-1:0]    joint_rd_data,
  input  logic              joint_rd_err,
  output logic              margx_rd_en,
  output logic [AW_X-1:0]   margx_rd_addr,
  input  logic [W_P-1:0]    margx_rd_data,
  output logic              margy_rd_en,
  output logic [AW_Y-1:0]   margy_rd_addr,
  input  logic [W_P-1:0]    margy_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_P-1:0]    out_p_joint,
  output logic [W_P-1:0]    out_p_marg_x,
  output logic [W_P-1:0]    out_p_marg_y,
  output logic              out_last,
  output logic              out_poison
);

  ime_stream_state_e state;
  ime_stream_state_e state_next;

  logic [AW_X-1:0] x_cnt;
  logic [AW_X-1:0] x_max;
  logic [AW_Y-1:0] y_cnt;
  logic [AW_Y-1:0] y_max;
  logic [AW_J-1:0] j_addr;
  logic            mode_err;
  logic            inflight;
  logic            inflight_last;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  logic            cfg_ok;
  logic            cell_last;
  logic            room;
  logic            issue;
  logic            pop;
  logic            last_pop;
  logic [1:0]      fifo_count;
  logic            fifo_valid;
  ime_beat_t       fifo_in;
  ime_beat_t       fifo_out;

  assign cfg_ok = (n_x != W_N'(0)) && (n_x <= W_N'(N_X_MAX)) &&
                  (n_y != W_N'(0)) && (n_y <= W_N'(N_Y_MAX));

  assign cell_last = (x_cnt == x_max) && (y_cnt == y_max);
  assign pop       = fifo_valid & out_ready;
  assign last_pop  = pop & fifo_out.last;

  // A new read may go out only if the FIFO will still have a slot when its data lands.
  assign room = (3'(fifo_count) + 3'(inflight)) < (3'd2 + 3'(pop));

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = cfg_ok ? RUN : DONE;
        end
      end
      RUN: begin
        issue = room;
        if (room && cell_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Cell counters, configuration latches and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt         <= '0;
      x_max         <= '0;
      y_cnt         <= '0;
      y_max         <= '0;
      j_addr        <= '0;
      mode_err      <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue & cell_last;
      busy_q        <= (state_next == RUN) || (state_next == DRAIN);
      done_q        <= (state_next == DONE);
      if ((state == IDLE) && start) begin
        err_q <= !cfg_ok;
        if (cfg_ok) begin
          x_max    <= AW_X'(n_x - W_N'(1));
          y_max    <= AW_Y'(n_y - W_N'(1));
          mode_err <= !mode_exact1(mode_onehot, MODE_MI_BIT);
          x_cnt    <= '0;
          y_cnt    <= '0;
          j_addr   <= '0;
        end
      end else if (issue && !cell_last) begin
        // Final cell leaves the counters parked so the addresses hold.
        j_addr <= j_addr + AW_J'(1);
        if (y_cnt == y_max) begin
          y_cnt <= '0;
          x_cnt <= x_cnt + AW_X'(1);
        end else begin
          y_cnt <= y_cnt + AW_Y'(1);
        end
      end
    end
  end

  assign fifo_in.p_joint  = joint_rd_data;
  assign fifo_in.p_marg_x = margx_rd_data;
  assign fifo_in.p_marg_y = margy_rd_data;
  assign fifo_in.last     = inflight_last;
  assign fifo_in.poison   = joint_rd_err | mode_err;

  ime_stream_fifo2 #(
    .W (BEAT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   (fifo_in),
    .pop   (pop),
    .dout  (fifo_out),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign joint_rd_en   = issue;
  assign margx_rd_en   = issue;
  assign margy_rd_en   = issue;
  assign joint_rd_addr = j_addr;
  assign margx_rd_addr = x_cnt;
  assign margy_rd_addr = y_cnt;
  assign out_valid     = fifo_valid;
  assign out_p_joint   = fifo_out.p_joint;
  assign out_p_marg_x  = fifo_out.p_marg_x;
  assign out_p_marg_y  = fifo_out.p_marg_y;
  assign out_last      = fifo_out.last;
  assign out_poison    = fifo_out.poison;

endmodule

// File: tb/tb_ime_joint_streamer.sv
// Randomized bench for ime_joint_streamer against a loop-based cell-order reference model.
module tb_ime_joint_streamer;
  import ime_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [W_N-1:0]    n_x;
  logic [W_N-1:0]    n_y;
  logic [W_MODE-1:0] mode_onehot;
  logic              busy, done, err;
  logic              joint_rd_en, margx_rd_en, margy_rd_en;
  logic [AW_J-1:0]   joint_rd_addr;
  logic [AW_X-1:0]   margx_rd_addr;
  logic [AW_Y-1:0]   margy_rd_addr;
  logic [W_P-1:0]    joint_rd_data, margx_rd_data, margy_rd_data;
  logic              joint_rd_err;
  logic              out_valid, out_ready, out_last, out_poison;
  logic [W_P-1:0]    out_p_joint, out_p_marg_x, out_p_marg_y;

  ime_joint_streamer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .n_x           (n_x),
    .n_y           (n_y),
    .mode_onehot   (mode_onehot),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .joint_rd_en   (joint_rd_en),
    .joint_rd_addr (joint_rd_addr),
    .joint_rd_data (joint_rd_data),
    .joint_rd_err  (joint_rd_err),
    .margx_rd_en   (margx_rd_en),
    .margx_rd_addr (margx_rd_addr),
    .margx_rd_data (margx_rd_data),
    .margy_rd_en   (margy_rd_en),
    .margy_rd_addr (margy_rd_addr),
    .margy_rd_data (margy_rd_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_p_joint   (out_p_joint),
    .out_p_marg_x  (out_p_marg_x),
    .out_p_marg_y  (out_p_marg_y),
    .out_last      (out_last),
    .out_poison    (out_poison)
  );

  always #5 clk = ~clk;

  logic [W_P-1:0] jmem [0:4095];
  logic           jerr [0:4095];
  logic [W_P-1:0] mx   [0:63];
  logic [W_P-1:0] my   [0:63];

  // Memory models with one-cycle read latency; junk is returned when not read.
  always @(posedge clk) begin
    if (joint_rd_en) begin
      joint_rd_data <= jmem[joint_rd_addr];
      joint_rd_err  <= jerr[joint_rd_addr];
    end else begin
      joint_rd_data <= 16'hdead;
      joint_rd_err  <= 1'b1;
    end
    margx_rd_data <= margx_rd_en ? mx[margx_rd_addr] : 16'hbeef;
    margy_rd_data <= margy_rd_en ? my[margy_rd_addr] : 16'hcafe;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [49:0] exp_q [$];
  int          total, cur_ny, rd_idx, issued, popped, beats, done_cnt;
  int          rmode, k_cyc;
  bit          mon_en;
  logic        prev_v, prev_r, pop_now;
  logic [49:0] prev_pl, pl, e;

  assign pl = {out_p_joint, out_p_marg_x, out_p_marg_y, out_last, out_poison};

  // Observe read issue order, FIFO occupancy bound, stall stability and beat contents.
  always @(negedge clk) begin
    if (!rst && mon_en) begin
      pop_now = out_valid && out_ready;
      if (joint_rd_en || margx_rd_en || margy_rd_en) begin
        check("rd_en_group", 64'({joint_rd_en, margx_rd_en, margy_rd_en}), 64'(3'b111));
        check("occupancy", 64'((issued - popped - int'(pop_now)) < 2), 64'(1));
        if (rd_idx < total) begin
          check("joint_addr", 64'(joint_rd_addr), 64'(rd_idx));
          check("margx_addr", 64'(margx_rd_addr), 64'(rd_idx / cur_ny));
          check("margy_addr", 64'(margy_rd_addr), 64'(rd_idx % cur_ny));
        end else begin
          check("read_count", 64'(rd_idx + 1), 64'(total));
        end
        rd_idx++;
        issued++;
      end
      if (prev_v && !prev_r) begin
        check("stall_hold", {13'd0, out_valid, pl}, {13'd0, 1'b1, prev_pl});
      end
      if (pop_now) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'(beats + 1), 64'(total));
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'(pl), 64'(e));
        end
        beats++;
        popped++;
      end
      if (done) done_cnt++;
      prev_v  = out_valid;
      prev_r  = out_ready;
      prev_pl = pl;
    end else begin
      prev_v = 1'b0;
    end
  end

  function automatic logic ready_fn(input int rm, input int k);
    int idx;
    idx = k - 3;
    case (rm)
      1: begin
        if (idx < 0 || idx > 8) return 1'b1;
        return (idx == 0) || (idx == 2);
      end
      2:       return ($urandom_range(0, 3) != 0);
      3:       return ($urandom_range(0, 1) != 0);
      default: return 1'b1;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    k_cyc++;
    out_ready = ready_fn(rmode, k_cyc);
  endtask

  task automatic fill_mem(input bit pattern);
    for (int a = 0; a < 4096; a++) begin
      jmem[a] = pattern ? 16'(16'h0100 + a) : 16'($urandom);
      jerr[a] = pattern ? 1'b0 : ($urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < 64; i++) begin
      mx[i] = pattern ? 16'(16'h0010 + i) : 16'($urandom);
      my[i] = pattern ? 16'(16'h0020 + i) : 16'($urandom);
    end
  endtask

  task automatic run_pass(input int nx, input int ny, input logic [4:0] mode,
                          input int rm, input bit extra_start, input bit do_reset);
    bit          legal;
    int          cnt;
    int          budget;
    int          a;
    logic [49:0] b;
    legal  = (nx >= 1) && (nx <= 64) && (ny >= 1) && (ny <= 64);
    total  = legal ? nx * ny : 0;
    cur_ny = (ny > 0) ? ny : 1;
    exp_q.delete();
    if (legal) begin
      for (int x = 0; x < nx; x++) begin
        for (int y = 0; y < ny; y++) begin
          a = x * ny + y;
          b = {jmem[a], mx[x], my[y], 1'((x == nx - 1) && (y == ny - 1)),
               jerr[a] | (mode != 5'b00010)};
          exp_q.push_back(b);
        end
      end
    end
    rd_idx = 0; issued = 0; popped = 0; beats = 0; done_cnt = 0;
    rmode = rm; k_cyc = 0;
    out_ready   = ready_fn(rm, 0);
    n_x         = 16'(nx);
    n_y         = 16'(ny);
    mode_onehot = mode;
    start       = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'(legal));
    check("err_after_start", 64'(err), 64'(!legal));
    check("done_after_start", 64'(done), 64'(!legal));
    check("rd_en_after_start", 64'(joint_rd_en), 64'(legal));
    if (legal) begin
      step();
      check("valid_e1", 64'(out_valid), 64'(0));
      step();
      check("valid_e2", 64'(out_valid), 64'(1));
    end
    budget = 8 * total + 40;
    cnt    = 0;
    while ((done_cnt == 0) && (cnt < budget) && !(do_reset && (beats >= 3))) begin
      if (extra_start && (cnt == 1)) begin
        start = 1'b1; n_x = 16'd1; n_y = 16'd1;
      end else begin
        start = 1'b0; n_x = 16'(nx); n_y = 16'(ny);
      end
      step();
      cnt++;
    end
    start = 1'b0;
    if (do_reset) begin
      rst    = 1'b1;
      mon_en = 1'b0;
      step();
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_rd_en", 64'(joint_rd_en), 64'(0));
      rst = 1'b0;
      exp_q.delete();
      step();
      mon_en = 1'b1;
    end else begin
      step();
      step();
      check("done_count", 64'(done_cnt), 64'(1));
      check("beat_count", 64'(beats), 64'(total));
      check("read_total", 64'(rd_idx), 64'(total));
      check("exp_left", 64'(exp_q.size()), 64'(0));
      check("busy_end", 64'(busy), 64'(0));
      check("err_end", 64'(err), 64'(!legal));
      check("valid_end", 64'(out_valid), 64'(0));
      check("rd_en_end", 64'(joint_rd_en), 64'(0));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; n_x = '0; n_y = '0; mode_onehot = '0;
    out_ready = 1'b1; mon_en = 1'b0; rmode = 0; k_cyc = 0;
    prev_v = 1'b0; prev_r = 1'b0; prev_pl = '0;
    total = 0; cur_ny = 1; rd_idx = 0; issued = 0; popped = 0; beats = 0; done_cnt = 0;
    fill_mem(1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 64'(out_valid), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_err", 64'(err), 64'(0));
    check("reset_rd_en", 64'({joint_rd_en, margx_rd_en, margy_rd_en}), 64'(0));
    check("reset_addr", 64'({joint_rd_addr, margx_rd_addr, margy_rd_addr}), 64'(0));
    check("reset_payload", 64'(pl), 64'(0));
    rst    = 1'b0;
    mon_en = 1'b1;
    step();

    run_pass(2, 3, 5'b00010, 0, 1'b0, 1'b0);
    run_pass(2, 3, 5'b00010, 1, 1'b0, 1'b0);
    run_pass(2, 3, 5'b00110, 0, 1'b0, 1'b0);
    jerr[4] = 1'b1;
    run_pass(2, 3, 5'b00010, 0, 1'b0, 1'b0);
    jerr[4] = 1'b0;
    run_pass(2, 0, 5'b00010, 0, 1'b0, 1'b0);
    run_pass(65, 3, 5'b00010, 0, 1'b0, 1'b0);
    run_pass(2, 3, 5'b00010, 0, 1'b0, 1'b0);
    run_pass(3, 4, 5'b00010, 0, 1'b0, 1'b1);
    run_pass(3, 4, 5'b00010, 0, 1'b0, 1'b0);
    run_pass(1, 1, 5'b00010, 0, 1'b0, 1'b0);
    run_pass(3, 3, 5'b00010, 0, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      fill_mem(1'b0);
      run_pass(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)),
               (i % 3 == 0) ? 5'($urandom) : 5'b00010, (i % 2 == 0) ? 2 : 3,
               1'b0, 1'b0);
    end
    run_pass(64, 2, 5'b00010, 2, 1'b0, 1'b0);
    run_pass(1, 64, 5'b00010, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
